// File: rtl/lsu_controller.sv
// Memory-stage load/store sequencer: forms lane mask, aligned address and shifted store data,
// runs the request/accept/response handshake, stalls the pipeline and extends load results.
module lsu_controller #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_out_address,
  input  logic [31:0] op_b,
  input  logic        valid,
  input  logic        data_valid,
  input  logic [31:0] wrap_load_in,
  output logic        request,
  output logic        we_re,
  output logic [3:0]  mask,
  output logic [31:0] mem_addr,
  output logic [31:0] store_data_out,
  output logic [31:0] wrap_load_out,
  output logic        stall,
  output logic        misaligned,
  output logic        timeout
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam logic [3:0] LastCnt = 4'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, sdata_q, load_q, load_d;
  logic [2:0]  f3_q;
  logic [3:0]  mask_q, cnt_q, cnt_d;
  logic        we_q, timeout_q, timeout_d;
  logic        capture, load_cap;

  logic        access, is_b, is_h, mis;
  logic [3:0]  mask_new;
  logic [31:0] sdata_new;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign access = load | store;
  // funct3[1:0] selects size; any encoding that is neither byte nor half is handled as a word
  assign is_b   = (funct3[1:0] == 2'b00);
  assign is_h   = (funct3[1:0] == 2'b01);
  assign mis    = (is_h & alu_out_address[0]) |
                  (~is_b & ~is_h & (alu_out_address[1:0] != 2'b00));

  always_comb begin
    mask_new  = 4'b1111;
    sdata_new = op_b;
    if (is_b) begin
      mask_new  = 4'b0001 << alu_out_address[1:0];
      sdata_new = {24'b0, op_b[7:0]} << {alu_out_address[1:0], 3'b000};
    end else if (is_h) begin
      mask_new  = 4'b0011 << {alu_out_address[1], 1'b0};
      sdata_new = {16'b0, op_b[15:0]} << {alu_out_address[1], 4'b0000};
    end
  end

  assign lane_b = wrap_load_in[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = wrap_load_in[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    unique case (f3_q)
      3'b000:  load_d = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_d = {24'b0, lane_b};
      3'b001:  load_d = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_d = {16'b0, lane_h};
      default: load_d = wrap_load_in;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    load_cap  = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access && !mis) begin
          state_d = StReq;
          capture = 1'b1;
          cnt_d   = 4'd0;
        end
      end
      StReq: begin
        cnt_d = cnt_q + 4'd1;
        if (valid) begin
          if (we_q) begin
            state_d = StDone;
          end else if (data_valid) begin
            state_d  = StDone;
            load_cap = 1'b1;
          end else begin
            state_d = StWait;
          end
        end else if (cnt_q == LastCnt) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 4'd1;
        if (data_valid) begin
          state_d  = StDone;
          load_cap = 1'b1;
        end else if (cnt_q == LastCnt) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      sdata_q   <= '0;
      load_q    <= '0;
      f3_q      <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      if (capture) begin
        addr_q  <= alu_out_address;
        f3_q    <= funct3;
        sdata_q <= sdata_new;
        mask_q  <= mask_new;
        we_q    <= ~load;
      end
      if (load_cap) load_q <= load_d;
    end
  end

  assign request        = (state_q == StReq);
  assign we_re          = we_q;
  assign mask           = mask_q;
  assign mem_addr       = {addr_q[31:2], 2'b00};
  assign store_data_out = sdata_q;
  assign wrap_load_out  = load_q;
  assign timeout        = timeout_q;
  assign stall          = ~rst & (((state_q == StIdle) & access & ~mis) |
                                  (state_q == StReq) | (state_q == StWait));
  assign misaligned     = ~rst & (state_q == StIdle) & access & mis;

endmodule

// File: tb/tb_lsu_controller.sv
// Vector table plus hand-written timeout and reset sequences for lsu_controller.
module tb_lsu_controller;

  logic        clk = 1'b0;
  logic        rst, load, store, valid, data_valid;
  logic [2:0]  funct3;
  logic [31:0] alu_out_address, op_b, wrap_load_in;
  logic        request, we_re, stall, misaligned, timeout;
  logic [3:0]  mask;
  logic [31:0] mem_addr, store_data_out, wrap_load_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] opb;
    logic [31:0] rdata;
    int          req_wait;
    int          dv_delay;
    logic        mis;
    logic [3:0]  mask;
    logic [31:0] maddr;
    logic [31:0] sdata;
    logic [31:0] result;
  } vec_t;

  typedef struct {
    logic        is_load;
    logic [31:0] res;
    int          stall_n;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  vec_t post_rst;

  lsu_controller #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .load(load), .store(store), .funct3(funct3),
    .alu_out_address(alu_out_address), .op_b(op_b), .valid(valid),
    .data_valid(data_valid), .wrap_load_in(wrap_load_in), .request(request),
    .we_re(we_re), .mask(mask), .mem_addr(mem_addr), .store_data_out(store_data_out),
    .wrap_load_out(wrap_load_out), .stall(stall), .misaligned(misaligned),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_access(input vec_t v);
    exp_t e;
    int   sn;
    sn = 0;
    @(posedge clk); #1;
    load = v.ld; store = v.st; funct3 = v.f3; alu_out_address = v.addr;
    op_b = v.opb; wrap_load_in = v.rdata; valid = 1'b0; data_valid = 1'b0;
    if (!v.mis) begin
      e.is_load = v.ld;
      e.res     = v.result;
      e.stall_n = 2 + v.req_wait + v.dv_delay;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("idle_misaligned", misaligned, v.mis);
    if (v.mis) begin
      chk("mis_request", request, 0);
      chk("mis_stall", stall, 0);
      @(posedge clk); #1;
      load = 1'b0; store = 1'b0;
      @(negedge clk);
      chk("mis_stays_idle", request, 0);
      return;
    end
    if (stall) sn++;
    @(posedge clk); #1;
    load = 1'b0; store = 1'b0;
    for (int i = 0; i < v.req_wait; i++) begin
      @(negedge clk);
      chk("req_hold", request, 1);
      if (stall) sn++;
      @(posedge clk); #1;
    end
    valid = 1'b1;
    data_valid = v.ld && (v.dv_delay == 0);
    @(negedge clk);
    chk("request", request, 1);
    chk("we_re", we_re, v.st);
    chk("mask", mask, v.mask);
    chk("mem_addr", mem_addr, v.maddr);
    if (v.st) chk("store_data", store_data_out, v.sdata);
    if (stall) sn++;
    @(posedge clk); #1;
    valid = 1'b0; data_valid = 1'b0;
    if (v.ld && v.dv_delay > 0) begin
      for (int i = 1; i < v.dv_delay; i++) begin
        @(negedge clk);
        chk("wait_no_request", request, 0);
        if (stall) sn++;
        @(posedge clk); #1;
      end
      data_valid = 1'b1;
      @(negedge clk);
      if (stall) sn++;
      @(posedge clk); #1;
      data_valid = 1'b0;
    end
    @(negedge clk);
    chk("done_stall", stall, 0);
    chk("done_request", request, 0);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      if (e.is_load) chk("load_result", wrap_load_out, e.res);
      chk("stall_cycles", sn, e.stall_n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    //            ld    st    f3      addr          opb           rdata         rw dv mis  mask     maddr         sdata         result
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 1'b0, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0,        1, 0, 1'b0, 4'b1000, 32'h200, 32'hA5000000, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 3'b001, 32'h302, 32'h1234ABCD, 32'h0,        0, 0, 1'b0, 4'b1100, 32'h300, 32'hABCD0000, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h00008000, 0, 3, 1'b0, 4'b0010, 32'h100, 32'h0, 32'hFFFFFF80};
    vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'h101, 32'h0,        32'h00008000, 0, 3, 1'b0, 4'b0010, 32'h100, 32'h0, 32'h00000080};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h202, 32'h0,        32'h80010000, 0, 0, 1'b0, 4'b1100, 32'h200, 32'h0, 32'hFFFF8001};
    vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h202, 32'h0,        32'h80010000, 2, 1, 1'b0, 4'b1100, 32'h200, 32'h0, 32'h00008001};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h400, 32'h0,        32'h76543210, 0, 0, 1'b0, 4'b1111, 32'h400, 32'h0, 32'h76543210};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,   32'h0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 3'b001, 32'h103, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,   32'h0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h101, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,   32'h0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h003, 32'h0,        32'h7F000000, 0, 1, 1'b0, 4'b1000, 32'h0,   32'h0, 32'h0000007F};
    post_rst = '{1'b1, 1'b0, 3'b010, 32'h600, 32'h0,        32'hCAFEF00D, 0, 2, 1'b0, 4'b1111, 32'h600, 32'h0, 32'hCAFEF00D};

    rst = 1'b1; load = 1'b1; store = 1'b0; funct3 = 3'b010; alu_out_address = 32'h0;
    op_b = 32'h0; valid = 1'b0; data_valid = 1'b0; wrap_load_in = 32'h0;
    #12;
    chk("rst_request", request, 0);
    chk("rst_stall", stall, 0);
    chk("rst_misaligned", misaligned, 0);
    chk("rst_mask", mask, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_store_data", store_data_out, 0);
    chk("rst_load_out", wrap_load_out, 0);
    chk("rst_timeout", timeout, 0);
    @(posedge clk); #1;
    rst = 1'b0; load = 1'b0;

    for (int i = 0; i < 12; i++) do_access(vecs[i]);

    // Load whose data never arrives: 15 cycles in REQ/WAIT, then DONE with the timeout pulse
    @(posedge clk); #1;
    load = 1'b1; funct3 = 3'b010; alu_out_address = 32'h500; wrap_load_in = 32'h12345678;
    @(negedge clk);
    chk("to_idle_stall", stall, 1);
    @(posedge clk); #1;
    load = 1'b0; valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("to_pending_stall", stall, 1);
      chk("to_no_pulse", timeout, 0);
      @(posedge clk); #1;
      valid = 1'b0;
    end
    @(negedge clk);
    chk("to_pulse", timeout, 1);
    chk("to_done_stall", stall, 0);
    chk("to_load_held", wrap_load_out, 32'h0000007F);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_pulse_end", timeout, 0);
    chk("to_idle_request", request, 0);

    // Reset while waiting for read data
    @(posedge clk); #1;
    load = 1'b1; funct3 = 3'b000; alu_out_address = 32'h0;
    @(posedge clk); #1;
    load = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_wait_stall", stall, 1);
    load = 1'b1; rst = 1'b1;
    #1;
    chk("rst_wait_request", request, 0);
    chk("rst_wait_stall", stall, 0);
    chk("rst_wait_load_out", wrap_load_out, 0);
    chk("rst_wait_timeout", timeout, 0);
    @(posedge clk); #1;
    load = 1'b0; rst = 1'b0;
    do_access(post_rst);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_controller.md
# lsu_controller

Sequencing controller for the data-memory port of the pipeline's memory stage. It accepts one load or store per instruction from the memory-stage pipeline register, forms byte-lane mask, aligned address and lane-shifted store data, and runs the request/accept/response handshake with data memory. It stalls the pipeline until the access completes and returns the sign- or zero-extended load value. It also flags misaligned accesses and memory timeouts.

## Interface
- MAX_WAIT, 15: cycles allowed in REQ or WAIT before timeout (4-bit counter, 1..15)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load  in  1  memory-stage instruction is a load
- store  in  1  memory-stage instruction is a store; load wins if both set
- funct3  in  3  instruction[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU
- alu_out_address  in  32  effective byte address
- op_b  in  32  store source register value
- valid  in  1  memory accepted the current request
- data_valid  in  1  read data on wrap_load_in is valid
- wrap_load_in  in  32  raw 32-bit word read from memory
- request  out  1  access request to memory
- we_re  out  1  1 = write, 0 = read; meaningful only while request=1
- mask  out  4  byte-lane enables
- mem_addr  out  32  {addr[31:2], 2'b00}
- store_data_out  out  32  lane-shifted store data
- wrap_load_out  out  32  extended load result
- stall  out  1  hold the pipeline
- misaligned  out  1  access dropped due to alignment
- timeout  out  1  one-cycle pulse, access abandoned

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset → IDLE.
- IDLE:
  - If (load|store) and aligned: capture addr, funct3, shifted data, mask, and direction; go to REQ.
  - If misaligned (H with addr[0]=1, W with addr[1:0]≠0): assert misaligned combinationally, no request, no stall, stay IDLE.
- REQ: request=1, driven from captured registers.
  - valid=1 on a store → DONE.
  - valid=1 on a load with data_valid=1 → capture result, DONE.
  - valid=1 on a load with data_valid=0 → WAIT.
- WAIT: data_valid=1 → capture result, go to DONE.
- DONE: stall=0 for one cycle so the pipeline advances; go to IDLE.
- Timeout: counter clears on entry to REQ and increments in REQ/WAIT. If it reaches MAX_WAIT without the exit condition: timeout=1 for one cycle, go to DONE, wrap_load_out unchanged.
- stall = (IDLE & (load|store) & aligned) | REQ | WAIT. Combinational.
- Mask:
  - B: 4'b0001 << addr[1:0]
  - H: 4'b0011 << {addr[1],1'b0}
  - W or other funct3: 4'b1111
- Store data:
  - B: op_b[7:0] << 8·addr[1:0]
  - H: op_b[15:0] << 16·addr[1]
  - W: op_b
  - Unused lanes are 0.
- Load: select the lane by captured addr, then sign-extend (B, H) or zero-extend (BU, HU). W passes through. funct3 011/110/111 is treated as W.
- wrap_load_out is registered and holds until the next load completes.

## Timing
- Reset values (async):
  - State IDLE; request, we_re, mask, mem_addr, store_data_out, wrap_load_out, timeout all 0.
  - stall=0 and misaligned=0 while rst=1.
- Reset mid-access: request drops in the same cycle, nothing is captured.
- Minimum store: stall high 2 cycles (IDLE detect, REQ with valid), DONE on the 3rd cycle.
- Minimum load: stall high 2 cycles when valid and data_valid coincide; 3 cycles via WAIT. wrap_load_out is valid from the DONE cycle.
- Request outputs are stable from REQ entry until valid.
- The DONE cycle ignores load/store; back-to-back accesses start from the following IDLE cycle.

## Test plan
- SW: op_b=0xDEADBEEF, addr=0x100, valid in the first REQ cycle → request 1 cycle, we_re=1, mask=1111, mem_addr=0x100, stall 2 cycles.
- SB: op_b=0x000000A5, addr=0x203 → mask=1000, store_data_out=0xA5000000, mem_addr=0x200.
- LB: addr=0x101, wrap_load_in=0x00008000, data_valid 3 cycles after valid → wrap_load_out=0xFFFFFF80; LBU with the same inputs gives 0x00000080; stall drops in DONE.
- LW at 0x102 and LH at 0x103 → misaligned=1, request=0, stall=0; state stays IDLE.
- Load with data_valid never asserted, MAX_WAIT=15 → timeout pulse after 15 cycles, wrap_load_out retains its prior value, IDLE two cycles later.
- Assert rst during WAIT → request=0 and stall=0 immediately, wrap_load_out=0; the next load completes normally.
